// File: rtl/ps2_pkg.sv
// Shared scan-code constants and types for the PS/2 keyboard digit-entry path.
package ps2_pkg;

  // Prefix bytes of the set-2 make/break protocol
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Main-row digit keys 0..9
  localparam logic [7:0] SC_D0    = 8'h45;
  localparam logic [7:0] SC_D1    = 8'h16;
  localparam logic [7:0] SC_D2    = 8'h1E;
  localparam logic [7:0] SC_D3    = 8'h26;
  localparam logic [7:0] SC_D4    = 8'h25;
  localparam logic [7:0] SC_D5    = 8'h2E;
  localparam logic [7:0] SC_D6    = 8'h36;
  localparam logic [7:0] SC_D7    = 8'h3D;
  localparam logic [7:0] SC_D8    = 8'h3E;
  localparam logic [7:0] SC_D9    = 8'h46;

  // Keypad digit keys 0..9
  localparam logic [7:0] SC_KP0   = 8'h70;
  localparam logic [7:0] SC_KP1   = 8'h69;
  localparam logic [7:0] SC_KP2   = 8'h72;
  localparam logic [7:0] SC_KP3   = 8'h7A;
  localparam logic [7:0] SC_KP4   = 8'h6B;
  localparam logic [7:0] SC_KP5   = 8'h73;
  localparam logic [7:0] SC_KP6   = 8'h74;
  localparam logic [7:0] SC_KP7   = 8'h6C;
  localparam logic [7:0] SC_KP8   = 8'h75;
  localparam logic [7:0] SC_KP9   = 8'h7D;

  // Editing keys; Enter is also the keypad Enter when E0-prefixed
  localparam logic [7:0] SC_BS    = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Controller / keyboard response bytes that never belong to a key sequence
  localparam logic [7:0] RSP_ERR0 = 8'h00;
  localparam logic [7:0] RSP_ERR1 = 8'hFF;
  localparam logic [7:0] RSP_BAT  = 8'hAA;
  localparam logic [7:0] RSP_ACK  = 8'hFA;
  localparam logic [7:0] RSP_ECHO = 8'hEE;
  localparam logic [7:0] RSP_RSND = 8'hFE;

  // Prefix-tracking FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

  // One BCD digit
  typedef logic [3:0] bcd_t;

  // True for bytes that abort any partial prefix sequence and are otherwise ignored
  function automatic logic is_response(input logic [7:0] b);
    return (b == RSP_ERR0) || (b == RSP_ERR1) || (b == RSP_BAT) ||
           (b == RSP_ACK)  || (b == RSP_ECHO) || (b == RSP_RSND);
  endfunction

endpackage

// File: rtl/ps2_digit_lut.sv
// Combinational decode of a standard-set scan code into digit / editing-key classes.
module ps2_digit_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_digit,
  output bcd_t       digit,
  output logic       is_bs,
  output logic       is_esc,
  output logic       is_enter
);

  // Map main-row and keypad digits to their value; flag the three editing keys
  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    is_bs    = 1'b0;
    is_esc   = 1'b0;
    is_enter = 1'b0;
    case (code)
      SC_D0, SC_KP0: digit = 4'd0;
      SC_D1, SC_KP1: digit = 4'd1;
      SC_D2, SC_KP2: digit = 4'd2;
      SC_D3, SC_KP3: digit = 4'd3;
      SC_D4, SC_KP4: digit = 4'd4;
      SC_D5, SC_KP5: digit = 4'd5;
      SC_D6, SC_KP6: digit = 4'd6;
      SC_D7, SC_KP7: digit = 4'd7;
      SC_D8, SC_KP8: digit = 4'd8;
      SC_D9, SC_KP9: digit = 4'd9;
      SC_BS: begin
        is_digit = 1'b0;
        is_bs    = 1'b1;
      end
      SC_ESC: begin
        is_digit = 1'b0;
        is_esc   = 1'b1;
      end
      SC_ENTER: begin
        is_digit = 1'b0;
        is_enter = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_digit_entry.sv
// PS/2 scan-code consumer: tracks E0/F0 prefixes, suppresses typematic repeats
// and edits a right-aligned BCD entry buffer that is latched into value on Enter.
//
// Input handshake: code_valid is a one-cycle strobe qualifying code; every
// strobed byte is consumed in that cycle (no ready / backpressure). All effects
// appear on the registered outputs in the following cycle.
module ps2_digit_entry
  import ps2_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  code_valid,
  input  logic [7:0]            code,
  output logic [4*DIGITS-1:0]   digits,
  output logic [2:0]            digit_count,
  output logic [4*DIGITS-1:0]   value,
  output logic                  key_event,
  output logic                  entry_done,
  output logic                  overflow,
  output prefix_state_t         fsm_state
);

  localparam logic [2:0] MAX_COUNT = 3'(DIGITS);

  prefix_state_t        state_q, state_n;
  logic [8:0]           held_q, held_n;
  logic [4*DIGITS-1:0]  digits_n, value_n, shifted;
  logic [2:0]           count_n;
  logic                 key_n, done_n, ovf_n;
  logic                 make_act, make_ext;

  logic                 lut_is_digit, lut_is_bs, lut_is_esc, lut_is_enter;
  bcd_t                 lut_digit;

  ps2_digit_lut u_lut (
    .code     (code),
    .is_digit (lut_is_digit),
    .digit    (lut_digit),
    .is_bs    (lut_is_bs),
    .is_esc   (lut_is_esc),
    .is_enter (lut_is_enter)
  );

  assign fsm_state = state_q;

  // Buffer with the new digit shifted in at the least-significant nibble
  always_comb begin
    shifted      = digits << 4;
    shifted[3:0] = lut_digit;
  end

  // Prefix FSM next state, and which received bytes count as a make
  always_comb begin
    state_n  = state_q;
    make_act = 1'b0;
    make_ext = 1'b0;
    held_n   = held_q;
    if (code_valid) begin
      if (is_response(code)) begin
        state_n = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (code == SC_EXT)      state_n = ST_EXT;
            else if (code == SC_BRK) state_n = ST_BRK;
            else                     make_act = 1'b1;
          end
          ST_EXT: begin
            if (code == SC_BRK) begin
              state_n = ST_EXT_BRK;
            end else begin
              make_act = 1'b1;
              make_ext = 1'b1;
              state_n  = ST_IDLE;
            end
          end
          ST_BRK: begin
            if (held_q == {1'b0, code}) held_n = 9'd0;
            state_n = ST_IDLE;
          end
          ST_EXT_BRK: begin
            if (held_q == {1'b1, code}) held_n = 9'd0;
            state_n = ST_IDLE;
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end
    // A new (non-repeat) make is remembered so its typematic repeats are dropped
    if (make_act && ({make_ext, code} != held_q)) held_n = {make_ext, code};
  end

  // Buffer editing and pulse generation for accepted (non-repeat) makes
  always_comb begin
    digits_n = digits;
    count_n  = digit_count;
    value_n  = value;
    key_n    = 1'b0;
    done_n   = 1'b0;
    ovf_n    = 1'b0;
    if (make_act && ({make_ext, code} != held_q)) begin
      if (make_ext) begin
        if (code == SC_ENTER) begin
          value_n  = digits;
          digits_n = '0;
          count_n  = 3'd0;
          done_n   = 1'b1;
        end
      end else if (lut_is_digit) begin
        if (digit_count < MAX_COUNT) begin
          digits_n = shifted;
          count_n  = digit_count + 3'd1;
          key_n    = 1'b1;
        end else begin
          ovf_n    = 1'b1;
        end
      end else if (lut_is_bs) begin
        if (digit_count != 3'd0) begin
          digits_n = digits >> 4;
          count_n  = digit_count - 3'd1;
        end
      end else if (lut_is_esc) begin
        digits_n = '0;
        count_n  = 3'd0;
      end else if (lut_is_enter) begin
        value_n  = digits;
        digits_n = '0;
        count_n  = 3'd0;
        done_n   = 1'b1;
      end
    end
  end

  // State, held code, buffer, result and pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      held_q      <= 9'd0;
      digits      <= '0;
      digit_count <= 3'd0;
      value       <= '0;
      key_event   <= 1'b0;
      entry_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_n;
      held_q      <= held_n;
      digits      <= digits_n;
      digit_count <= count_n;
      value       <= value_n;
      key_event   <= key_n;
      entry_done  <= done_n;
      overflow    <= ovf_n;
    end
  end

endmodule

// File: tb/tb_ps2_digit_entry.sv
// Scoreboard bench for ps2_digit_entry: directed scan-code streams with
// hand-computed expected pulses and buffer states.
module tb_ps2_digit_entry;
  import ps2_pkg::*;

  localparam int DIGITS = 4;
  localparam int DW     = 4 * DIGITS;
  localparam int W      = 2 + DW + 3 + DW;

  localparam logic [1:0] EV_KEY  = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;
  localparam logic [1:0] EV_OVF  = 2'd3;

  logic          clk;
  logic          reset;
  logic          code_valid;
  logic [7:0]    code;
  logic [DW-1:0] digits;
  logic [2:0]    digit_count;
  logic [DW-1:0] value;
  logic          key_event;
  logic          entry_done;
  logic          overflow;
  prefix_state_t fsm_state;

  logic [W-1:0]  exp_q[$];
  int            checks;
  int            errors;

  logic [W-1:0]  act_w;
  logic [W-1:0]  exp_w;
  logic [1:0]    act_t;

  ps2_digit_entry #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .code_valid  (code_valid),
    .code        (code),
    .digits      (digits),
    .digit_count (digit_count),
    .value       (value),
    .key_event   (key_event),
    .entry_done  (entry_done),
    .overflow    (overflow),
    .fsm_state   (fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every output pulse pops one expected event and is compared
  always @(negedge clk) begin
    if (!reset && (key_event || entry_done || overflow)) begin
      if ((32'(key_event) + 32'(entry_done) + 32'(overflow)) != 1) act_t = 2'd0;
      else if (key_event)  act_t = EV_KEY;
      else if (entry_done) act_t = EV_DONE;
      else                 act_t = EV_OVF;
      act_w  = {act_t, digits, digit_count, value};
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse actual=%h (type,digits,count,value)", act_w);
      end else begin
        exp_w = exp_q.pop_front();
        if (act_w !== exp_w) begin
          errors = errors + 1;
          $display("FAIL pulse_event actual=%h required=%h", act_w, exp_w);
        end
      end
    end
  end

  // Driver: one byte per cycle, starting and ending on a falling edge
  task automatic send(input logic [7:0] b);
    code       = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    code       = 8'h00;
  endtask

  task automatic expect_evt(input logic [1:0] t, input logic [DW-1:0] d,
                            input logic [2:0] c, input logic [DW-1:0] v);
    exp_q.push_back({t, d, c, v});
  endtask

  // Idle until every expected pulse has been seen, bounded
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s missing_pulses actual_left=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_state(input string name, input logic [DW-1:0] d,
                             input logic [2:0] c, input logic [DW-1:0] v);
    checks = checks + 1;
    if (digits !== d || digit_count !== c || value !== v || fsm_state !== ST_IDLE) begin
      errors = errors + 1;
      $display("FAIL %s actual digits=%h count=%0d value=%h state=%0d required digits=%h count=%0d value=%h state=0",
               name, digits, digit_count, value, fsm_state, d, c, v);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    code_valid = 1'b0;
    code       = 8'h00;
    reset      = 1'b0;
    @(negedge clk);
    do_reset();

    checks = checks + 1;
    if (key_event !== 1'b0 || entry_done !== 1'b0 || overflow !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_pulses actual=%b%b%b required=000", key_event, entry_done, overflow);
    end
    check_state("reset_state", 16'h0000, 3'd0, 16'h0000);

    // Three digits with releases, back to back
    expect_evt(EV_KEY, 16'h0001, 3'd1, 16'h0000); send(SC_D1);
    send(SC_BRK); send(SC_D1);
    expect_evt(EV_KEY, 16'h0012, 3'd2, 16'h0000); send(SC_D2);
    send(SC_BRK); send(SC_D2);
    expect_evt(EV_KEY, 16'h0123, 3'd3, 16'h0000); send(SC_D3);
    send(SC_BRK); send(SC_D3);
    drain("three_digits");
    check_state("three_digits", 16'h0123, 3'd3, 16'h0000);

    // Backspace, escape, backspace on empty buffer (no pulses)
    send(SC_BS); send(SC_BRK); send(SC_BS);
    drain("backspace");
    check_state("backspace", 16'h0012, 3'd2, 16'h0000);
    send(SC_ESC); send(SC_BRK); send(SC_ESC);
    drain("escape");
    check_state("escape", 16'h0000, 3'd0, 16'h0000);
    send(SC_BS); send(SC_BRK); send(SC_BS);
    drain("backspace_empty");
    check_state("backspace_empty", 16'h0000, 3'd0, 16'h0000);

    // Typematic repeats produce a single key_event
    expect_evt(EV_KEY, 16'h0004, 3'd1, 16'h0000); send(SC_D4);
    send(SC_D4); send(SC_D4); send(SC_BRK); send(SC_D4);
    drain("typematic");
    check_state("typematic", 16'h0004, 3'd1, 16'h0000);
    send(SC_ESC); send(SC_BRK); send(SC_ESC);

    // Fill the buffer, fifth digit overflows
    expect_evt(EV_KEY, 16'h0001, 3'd1, 16'h0000); send(SC_D1); send(SC_BRK); send(SC_D1);
    expect_evt(EV_KEY, 16'h0012, 3'd2, 16'h0000); send(SC_D2); send(SC_BRK); send(SC_D2);
    expect_evt(EV_KEY, 16'h0121, 3'd3, 16'h0000); send(SC_D1); send(SC_BRK); send(SC_D1);
    expect_evt(EV_KEY, 16'h1212, 3'd4, 16'h0000); send(SC_D2); send(SC_BRK); send(SC_D2);
    expect_evt(EV_OVF, 16'h1212, 3'd4, 16'h0000); send(SC_D1); send(SC_BRK); send(SC_D1);
    drain("overflow");
    check_state("overflow", 16'h1212, 3'd4, 16'h0000);
    send(SC_ESC); send(SC_BRK); send(SC_ESC);

    // Keypad Enter latches 0x0047, then an ignored extended make
    expect_evt(EV_KEY, 16'h0004, 3'd1, 16'h0000); send(SC_D4); send(SC_BRK); send(SC_D4);
    expect_evt(EV_KEY, 16'h0047, 3'd2, 16'h0000); send(SC_D7); send(SC_BRK); send(SC_D7);
    expect_evt(EV_DONE, 16'h0000, 3'd0, 16'h0047); send(SC_EXT); send(SC_ENTER);
    send(SC_EXT); send(SC_BRK); send(SC_ENTER);
    send(SC_EXT); send(SC_KP0);
    drain("kp_enter");
    check_state("kp_enter", 16'h0000, 3'd0, 16'h0047);
    send(SC_EXT); send(SC_BRK); send(SC_KP0);

    // Reset in the middle of E0 F0 discards the prefix and clears value
    send(SC_EXT); send(SC_BRK);
    do_reset();
    check_state("mid_reset", 16'h0000, 3'd0, 16'h0000);
    expect_evt(EV_KEY, 16'h0000, 3'd1, 16'h0000); send(SC_D0);
    send(SC_BRK); send(SC_D0);
    drain("after_reset");
    check_state("after_reset", 16'h0000, 3'd1, 16'h0000);

    // Keypad digits, standard Enter, repeat suppression of Enter, Enter on empty
    expect_evt(EV_KEY, 16'h0009, 3'd2, 16'h0000); send(SC_KP9);
    send(SC_BRK); send(SC_KP9);
    expect_evt(EV_DONE, 16'h0000, 3'd0, 16'h0009); send(SC_ENTER);
    send(SC_ENTER); send(SC_BRK); send(SC_ENTER);
    expect_evt(EV_DONE, 16'h0000, 3'd0, 16'h0000); send(SC_ENTER);
    send(SC_BRK); send(SC_ENTER);
    drain("std_enter");
    check_state("std_enter", 16'h0000, 3'd0, 16'h0000);

    // A response byte after E0 returns to IDLE so the next byte is a standard make
    expect_evt(EV_KEY, 16'h0005, 3'd1, 16'h0000);
    send(SC_EXT); send(RSP_ACK); send(SC_D5);
    send(SC_BRK); send(SC_D5);
    // Unmapped code is ignored
    send(8'h1C); send(SC_BRK); send(8'h1C);
    drain("response_abort");
    check_state("response_abort", 16'h0005, 3'd1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ps2_digit_entry.md
# ps2_digit_entry

Downstream consumer of the PS/2 receiver's scan-code bytes. Interprets the make/break/extended prefix protocol, suppresses typematic repeats, and assembles digit keystrokes into a right-aligned BCD entry buffer with backspace, escape and enter editing. On Enter it latches the buffer into a result register for the 7-segment display path and application logic.

## Interface
Parameters:
- DIGITS, 4, BCD digits held in entry buffer and result register (1..7)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- code_valid  in  1  single-cycle strobe, new received scan byte on code
- code  in  8  scan-code byte
- digits  out  4*DIGITS  entry buffer, BCD; [3:0] = most recently typed digit
- digit_count  out  3  digits currently in buffer, 0..DIGITS
- value  out  4*DIGITS  result register, loaded on Enter
- key_event  out  1  one-cycle pulse, digit accepted into buffer
- entry_done  out  1  one-cycle pulse, Enter processed, value updated
- overflow  out  1  one-cycle pulse, digit make rejected, buffer full

## Operation
- Prefix FSM, states IDLE, EXT, BRK, EXT_BRK; advances only on code_valid.
- IDLE: 0xE0 -> EXT; 0xF0 -> BRK; other byte -> make handling (standard set), stay IDLE.
- EXT: 0xF0 -> EXT_BRK; other byte -> extended make handling -> IDLE.
- BRK: any byte = released code; if it equals held_code, clear held_code -> IDLE.
- EXT_BRK: any byte = released extended code; same held_code rule (extended flag must match) -> IDLE.
- 0x00, 0xFF, 0xAA, 0xFA, 0xEE, 0xFE in any state: no action, FSM -> IDLE, held_code unchanged.
- Typematic suppression: held_code (9 bits: ext flag + byte) records last accepted make; a make equal to held_code is ignored (no pulses, no buffer change). A different make overwrites held_code. Reset clears held_code to 0.
- Standard make keys: digits 0x45,16,1E,26,25,2E,36,3D,3E,46 -> 0..9; keypad 0x70,69,72,7A,6B,73,74,6C,75,7D -> 0..9; 0x66 backspace; 0x76 escape; 0x5A Enter.
- Extended make: only E0 5A (keypad Enter) acts, as Enter; all others ignored but still update held_code.
- Digit, count < DIGITS: digits <= {digits[4*DIGITS-5:0], d}; count+1; key_event.
- Digit, count == DIGITS: no change; overflow.
- Backspace: digits shift right by 4, top nibble 0; count-1; no-op at count 0.
- Escape: digits and count cleared.
- Enter: value <= digits; digits and count cleared; entry_done. Enter with count 0 loads value = 0.
- Unmapped standard codes: ignored, held_code updated.

## Timing
- All outputs registered; pulses and buffer/value updates visible the cycle after the code_valid cycle (latency 1).
- code_valid on consecutive cycles fully supported; each byte processed in its own cycle, no backpressure.
- Pulses exactly one cycle; at most one of key_event/entry_done/overflow per cycle.
- Reset (any time, incl. mid-prefix): FSM IDLE, digits, count, value, held_code 0, all pulses 0; a partial E0/F0 sequence is discarded.

## Structure
- Package ps2_pkg: scan-code constants (prefixes, digit/keypad/control codes, controller response codes), FSM state typedef, BCD nibble typedef.
- Sub-module ps2_digit_lut: combinational scan-code -> {is_digit, digit[3:0], is_bs, is_esc, is_enter}; shared with the display decoder.

## Test plan
- Reset, bytes 16,F0,16,1E,F0,1E,26,F0,26 -> key_event x3, digits 0x0123, count 3.
- Bytes 25,25,25,F0,25 (typematic) -> single key_event, digits 0x0004, count 1.
- With DIGITS=4: 16,F0,16 repeated with 16/1E alternating five times -> 4 key_event then overflow on fifth, digits unchanged.
- Buffer 0x0123: 66,F0,66 -> digits 0x0012, count 2; 76,F0,76 -> digits 0, count 0; backspace at count 0 -> no change.
- Buffer 0x0047: E0,5A,E0,F0,5A -> entry_done, value 0x0047, digits 0, count 0; E0,70 ignored (no key_event).
- Assert reset after E0,F0 mid-sequence; then 45 -> treated as make, key_event, digits 0x0000, count 1.
